// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I core: opcodes, controller states,
// datapath mux selects and the per-state control word.
package riscv_pkg;

  localparam int OP_W    = 7;
  localparam int STATE_W = 4;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // fetch/branch/decode are qualified later by MemReady, Zero and the opcode.
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       decode;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch      = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.decode    = 1'b1;
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
        c.mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_RS2;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_RS1;
        c.alu_src_b  = SRCB_RS2;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] imm_src_for_op(input logic [OP_W-1:0] op);
    logic [1:0] imm;
    case (op)
      OP_LW, OP_I: imm = IMM_I;
      OP_SW:       imm = IMM_S;
      OP_BEQ:      imm = IMM_B;
      OP_JAL:      imm = IMM_J;
      default:     imm = IMM_I;
    endcase
    return imm;
  endfunction

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp plus instruction function bits onto ALUControl.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // addi never subtracts: IR[30] is immediate data when op[5] is clear.
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: steps one instruction at a time through
// fetch, decode, execute, memory and writeback, sharing one ALU and one memory port.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7b5_i,
  input  logic            Zero_i,
  input  logic            MemReady_i,
  output logic            PCWrite_o,
  output logic            AdrSrc_o,
  output logic            MemWrite_o,
  output logic            IRWrite_o,
  output logic            RegWrite_o,
  output logic [1:0]      ResultSrc_o,
  output logic [1:0]      ALUSrcA_o,
  output logic [1:0]      ALUSrcB_o,
  output logic [2:0]      ALUControl_o,
  output logic [1:0]      ImmSrc_o,
  output logic            IllegalOp_o
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  logic   fetch_go;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = MemReady_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = MemReady_i ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = MemReady_i ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // The control word is registered alongside the state, so it is looked up for state_d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  // Terms that depend on same-cycle inputs stay combinational and are masked during reset.
  assign fetch_go    = rst_n & ctrl_q.fetch & MemReady_i;
  assign IRWrite_o   = fetch_go;
  assign PCWrite_o   = fetch_go | (rst_n & (ctrl_q.pc_update | (ctrl_q.branch & Zero_i)));
  assign IllegalOp_o = rst_n & ctrl_q.decode & ~op_supported(op_i);

  assign AdrSrc_o    = ctrl_q.adr_src;
  assign MemWrite_o  = ctrl_q.mem_write;
  assign RegWrite_o  = ctrl_q.reg_write;
  assign ResultSrc_o = ctrl_q.result_src;
  assign ALUSrcA_o   = ctrl_q.alu_src_a;
  assign ALUSrcB_o   = ctrl_q.alu_src_b;
  assign ImmSrc_o    = imm_src_for_op(op_i);

  alu_decoder u_alu_decoder (
    .alu_op_i      (ctrl_q.alu_op),
    .funct3_i      (funct3_i),
    .funct7b5_i    (funct7b5_i),
    .op5_i         (op_i[5]),
    .alu_control_o (ALUControl_o)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each stimulated cycle queues a hand-computed
// output vector, and a negedge monitor pops and compares it against the DUT.
module tb_multicycle_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ILL  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       Zero_i;
  logic       MemReady_i;
  logic       PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, RegWrite_o, IllegalOp_o;
  logic [1:0] ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ImmSrc_o;
  logic [2:0] ALUControl_o;

  int checks = 0;
  int fails  = 0;

  logic [16:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_i         (op_i),
    .funct3_i     (funct3_i),
    .funct7b5_i   (funct7b5_i),
    .Zero_i       (Zero_i),
    .MemReady_i   (MemReady_i),
    .PCWrite_o    (PCWrite_o),
    .AdrSrc_o     (AdrSrc_o),
    .MemWrite_o   (MemWrite_o),
    .IRWrite_o    (IRWrite_o),
    .RegWrite_o   (RegWrite_o),
    .ResultSrc_o  (ResultSrc_o),
    .ALUSrcA_o    (ALUSrcA_o),
    .ALUSrcB_o    (ALUSrcB_o),
    .ALUControl_o (ALUControl_o),
    .ImmSrc_o     (ImmSrc_o),
    .IllegalOp_o  (IllegalOp_o)
  );

  // Vector layout: pcw adr mw irw rw | res | srcA | srcB | aluc | imm | ill
  function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] res,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] aluc, input logic [1:0] imm,
                                     input logic ill);
    return {pcw, adr, mw, irw, rw, res, sa, sb, aluc, imm, ill};
  endfunction

  // Monitor: compare every cycle for which the driver queued an expectation.
  initial begin
    logic [16:0] act;
    logic [16:0] exp;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {PCWrite_o, AdrSrc_o, MemWrite_o, IRWrite_o, RegWrite_o, ResultSrc_o,
               ALUSrcA_o, ALUSrcB_o, ALUControl_o, ImmSrc_o, IllegalOp_o};
        checks++;
        if (act !== exp) begin
          fails++;
          $display("FAIL %s: got %b_%b_%b_%b_%b_%b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b_%b_%b_%b_%b_%b",
                   nm, act[16], act[15], act[14], act[13], act[12], act[11:10], act[9:8],
                   act[7:6], act[5:3], act[2:1], act[0], exp[16], exp[15], exp[14],
                   exp[13], exp[12], exp[11:10], exp[9:8], exp[7:6], exp[5:3], exp[2:1], exp[0]);
        end else begin
          $display("ok   %s: %b", nm, act);
        end
      end
    end
  end

  // Drive one cycle's inputs (op/funct come from the current globals) and queue its expectation.
  task automatic step(input string name, input logic z, input logic mr, input logic [16:0] exp);
    Zero_i     = z;
    MemReady_i = mr;
    name_q.push_back(name);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    op_i       = op;
    funct3_i   = f3;
    funct7b5_i = f7;
  endtask

  // Four-cycle ALU instruction (R or I) with MemReady high; srcb and aluc hand-supplied.
  task automatic alu_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [1:0] sb, input logic [2:0] aluc);
    set_instr(op, f3, f7);
    step({nm, " FETCH"},  1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0));
    step({nm, " DECODE"}, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b00,1'b0));
    step({nm, " EXEC"},   1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,sb,aluc,2'b00,1'b0));
    step({nm, " ALUWB"},  1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000,2'b00,1'b0));
  endtask

  initial begin
    rst_n = 1'b0;
    set_instr(LW, 3'b010, 1'b0);
    Zero_i     = 1'b0;
    MemReady_i = 1'b1;
    @(posedge clk);
    #1;

    step("reset held", 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0));
    rst_n = 1'b1;

    // lw, MemReady high throughout: five cycles
    step("lw FETCH",   1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0));
    step("lw DECODE",  1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b00,1'b0));
    step("lw MEMADR",  1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,2'b00,1'b0));
    step("lw MEMREAD", 1'b0, 1'b1, mk(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,2'b00,1'b0));
    step("lw MEMWB",   1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,3'b000,2'b00,1'b0));

    // second lw, aborted by reset while waiting in MEMREAD
    step("lw2 FETCH",   1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0));
    step("lw2 DECODE",  1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b00,1'b0));
    step("lw2 MEMADR",  1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,2'b00,1'b0));
    step("lw2 MEMREAD wait", 1'b0, 1'b0, mk(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,2'b00,1'b0));
    rst_n = 1'b0;
    step("reset mid-MEMREAD", 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0));
    rst_n = 1'b1;

    // sw with three wait cycles in MEMWRITE
    set_instr(SW, 3'b010, 1'b0);
    step("sw FETCH after reset", 1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,2'b01,1'b0));
    step("sw DECODE",  1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b01,1'b0));
    step("sw MEMADR",  1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,2'b01,1'b0));
    for (int i = 0; i < 3; i++)
      step($sformatf("sw MEMWRITE wait%0d", i), 1'b0, 1'b0,
           mk(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,2'b01,1'b0));
    step("sw MEMWRITE done", 1'b0, 1'b1, mk(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,2'b01,1'b0));

    // beq taken, with one fetch wait first (also shows sw returned to FETCH)
    set_instr(BEQ, 3'b000, 1'b0);
    step("beq FETCH wait", 1'b0, 1'b0, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,3'b000,2'b10,1'b0));
    step("beq FETCH",      1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,2'b10,1'b0));
    step("beq DECODE",     1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b10,1'b0));
    step("beq taken",      1'b1, 1'b1, mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,2'b10,1'b0));
    // beq not taken; Zero high in DECODE must not leak onto PCWrite
    step("beq2 FETCH",     1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,2'b10,1'b0));
    step("beq2 DECODE z1", 1'b1, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b10,1'b0));
    step("beq not taken",  1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'b001,2'b10,1'b0));

    alu_instr("R sub",      RTY, 3'b000, 1'b1, 2'b00, 3'b001);
    alu_instr("addi f7=1",  ITY, 3'b000, 1'b1, 2'b01, 3'b000);
    alu_instr("R and",      RTY, 3'b111, 1'b0, 2'b00, 3'b010);
    alu_instr("R or",       RTY, 3'b110, 1'b0, 2'b00, 3'b011);
    alu_instr("slti",       ITY, 3'b010, 1'b0, 2'b01, 3'b101);

    set_instr(JAL, 3'b000, 1'b0);
    step("jal FETCH",  1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,2'b11,1'b0));
    step("jal DECODE", 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b11,1'b0));
    step("jal JAL",    1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,3'b000,2'b11,1'b0));
    step("jal ALUWB",  1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'b000,2'b11,1'b0));

    set_instr(ILL, 3'b000, 1'b0);
    step("ill FETCH",   1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0));
    step("ill DECODE",  1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,2'b00,1'b1));
    step("ill back to FETCH", 1'b0, 1'b0, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0));
    step("ill FETCH go", 1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b10,3'b000,2'b00,1'b0));

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
